pattern_entry: RTL and testbench

Upstream input stage for the 5x5 Hopfield recall engine. Debounces the board's active-low buttons, lets the user move a cursor over the 5x5 grid and toggle cells, and optionally corrupts the finished pattern with pseudo-random bit flips. The committed pattern is delivered to the recall engine over a valid/ready handshake. It also exports the live edit buffer and a cursor blink for the LED matrix overlay.

---
 rtl/neuro_pkg.sv | 44 ++++
 rtl/btn_debounce.sv | 56 +++++
 rtl/pattern_entry.sv | 157 +++++++++++++++
 tb/tb_pattern_entry.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuro_pkg.sv
// Shared definitions for the 5x5 Hopfield pattern front end:
// grid geometry, entry FSM states, LFSR constants and small helpers.
package neuro_pkg;

  localparam int GRID  = 5;
  localparam int NCELL = GRID * GRID;

  // Entry FSM: editing, applying noise flips, offering the pattern.
  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    NOISE = 2'd1,
    OFFER = 2'd2
  } state_t;

  // Observation bundle for checkers and bring-up.
  typedef struct packed {
    state_t     state;
    logic [3:0] flips_left;
    logic [5:0] btn_level;
  } dbg_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps, 1-based bit positions 16,14,13,11.
  localparam int TAP_A = 16;
  localparam int TAP_B = 14;
  localparam int TAP_C = 13;
  localparam int TAP_D = 11;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[TAP_A-1] ^ v[TAP_B-1] ^ v[TAP_C-1] ^ v[TAP_D-1];
    return {v[14:0], fb};
  endfunction

  // Row/column stepping with wrap-around over 0..4.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one active-low raw button: 2-FF synchronizer, stability
// counter, and a one-cycle press pulse on the debounced 1->0 transition.
module btn_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_press;
  logic [DB_BITS-1:0] r_cnt;

  // Bring the asynchronous raw level into the clock domain (idle = released).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after 2^DB_BITS consecutive differing cycles;
  // any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == {DB_BITS{1'b1}}) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_level & ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/pattern_entry.sv
// Pattern entry stage: debounced buttons drive a cursor and toggle cells of
// a 5x5 edit buffer; commit snapshots it (optionally noised) and offers it.
//
// Handshake: pat_valid is high exactly while the FSM is in OFFER. pat_data is
// frozen for that whole interval. A transfer happens on the clock edge where
// pat_valid and pat_ready are both high; the FSM then returns to EDIT. Only
// reset can drop pat_valid without a transfer.
module pattern_entry
  import neuro_pkg::*;
#(
  parameter int DB_BITS     = 16,
  parameter int NOISE_FLIPS = 3,
  parameter int BLINK_BIT   = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        btn,
  input  logic              Abtn,
  input  logic              Bbtn,
  input  logic              noise_en,
  output logic [NCELL-1:0]  edit_buf,
  output logic [4:0]        cursor,
  output logic              blink,
  output logic              pat_valid,
  input  logic              pat_ready,
  output logic [NCELL-1:0]  pat_data,
  output dbg_t              dbg
);

  localparam logic [4:0] NCELL5 = 5'(NCELL);

  logic [5:0]         w_raw;
  logic [5:0]         w_level;
  logic [5:0]         w_press;
  logic [4:0]         w_idx;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_do_commit;
  logic               w_do_toggle;
  logic               w_do_up;
  logic               w_do_down;
  logic               w_do_left;
  logic               w_do_right;
  logic               w_flip_en;
  logic [2:0]         r_row;
  logic [2:0]         r_col;
  logic [NCELL-1:0]   r_edit;
  logic [NCELL-1:0]   r_pat;
  logic [3:0]         r_flip_cnt;
  logic [15:0]        r_lfsr;
  logic [BLINK_BIT:0] r_blink_cnt;

  // Raw inputs: [3:0] up/down/left/right, [4] toggle, [5] commit.
  assign w_raw = {Bbtn, Abtn, btn};

  for (genvar i = 0; i < 6; i++) begin : g_db
    btn_debounce #(.DB_BITS(DB_BITS)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (w_raw[i]),
      .level (w_level[i]),
      .press (w_press[i])
    );
  end

  assign w_idx = r_lfsr[4:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EDIT;
    else      r_state <= w_state_nxt;
  end

  // Next state and one-hot action strobes; only the highest-priority event acts.
  always_comb begin
    w_state_nxt = r_state;
    w_do_commit = 1'b0;
    w_do_toggle = 1'b0;
    w_do_up     = 1'b0;
    w_do_down   = 1'b0;
    w_do_left   = 1'b0;
    w_do_right  = 1'b0;
    w_flip_en   = 1'b0;
    case (r_state)
      EDIT: begin
        if (w_press[5]) begin
          w_do_commit = 1'b1;
          w_state_nxt = (noise_en && (NOISE_FLIPS > 0)) ? NOISE : OFFER;
        end else if (w_press[4]) begin
          w_do_toggle = 1'b1;
        end else if (w_press[0]) begin
          w_do_up = 1'b1;
        end else if (w_press[1]) begin
          w_do_down = 1'b1;
        end else if (w_press[2]) begin
          w_do_left = 1'b1;
        end else if (w_press[3]) begin
          w_do_right = 1'b1;
        end
      end
      NOISE: begin
        // Out-of-grid LFSR indices are skipped without consuming a flip.
        if (w_idx < NCELL5) begin
          w_flip_en = 1'b1;
          if (r_flip_cnt == 4'd1) w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (pat_ready) w_state_nxt = EDIT;
      end
      default: w_state_nxt = EDIT;
    endcase
  end

  // Cursor, edit buffer, committed pattern, flip counter and free-running LFSR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_edit     <= '0;
      r_pat      <= '0;
      r_flip_cnt <= 4'd0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (w_do_toggle) r_edit <= r_edit ^ (25'd1 << cursor);
      if (w_do_up)     r_row  <= wrap_dec(r_row);
      if (w_do_down)   r_row  <= wrap_inc(r_row);
      if (w_do_left)   r_col  <= wrap_dec(r_col);
      if (w_do_right)  r_col  <= wrap_inc(r_col);
      if (w_do_commit) begin
        r_pat      <= r_edit;
        r_flip_cnt <= 4'(NOISE_FLIPS);
      end else if (w_flip_en) begin
        r_pat      <= r_pat ^ (25'd1 << w_idx);
        r_flip_cnt <= r_flip_cnt - 4'd1;
      end
    end
  end

  // Free-running counter for the cursor blink overlay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_blink_cnt <= '0;
    else      r_blink_cnt <= r_blink_cnt + 1'b1;
  end

  assign cursor    = ({2'b00, r_row} << 2) + {2'b00, r_row} + {2'b00, r_col};
  assign edit_buf  = r_edit;
  assign pat_data  = r_pat;
  assign pat_valid = (r_state == OFFER);
  assign blink     = r_blink_cnt[BLINK_BIT];

  assign dbg.state      = r_state;
  assign dbg.flips_left = r_flip_cnt;
  assign dbg.btn_level  = w_level;

endmodule

// File: tb/tb_pattern_entry.sv
// Bench for pattern_entry: table-driven edits, hand-written commit/handshake
// sequences, randomized button events against a grid-level reference model.
module tb_pattern_entry;
  import neuro_pkg::*;

  localparam int NF = 3;
  localparam int BB = 4;

  localparam logic [5:0] M_UP = 6'b000001;
  localparam logic [5:0] M_DN = 6'b000010;
  localparam logic [5:0] M_LT = 6'b000100;
  localparam logic [5:0] M_RT = 6'b001000;
  localparam logic [5:0] M_TG = 6'b010000;
  localparam logic [5:0] M_CM = 6'b100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn = 4'hF;
  logic        Abtn = 1'b1;
  logic        Bbtn = 1'b1;
  logic        noise_en = 1'b0;
  logic        pat_ready = 1'b0;
  logic [24:0] edit_buf;
  logic [4:0]  cursor;
  logic        blink;
  logic        pat_valid;
  logic [24:0] pat_data;
  dbg_t        dbg;

  pattern_entry #(.DB_BITS(2), .NOISE_FLIPS(NF), .BLINK_BIT(BB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .Abtn      (Abtn),
    .Bbtn      (Bbtn),
    .noise_en  (noise_en),
    .edit_buf  (edit_buf),
    .cursor    (cursor),
    .blink     (blink),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .dbg       (dbg)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int n = 0;              // clock edges since reset release
  int rise_cyc = -1;      // cycle index where pat_valid last rose
  int vhigh_cnt = 0;      // cycles observed with pat_valid high
  logic prev_v = 1'b0;
  int last_drive = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  always @(negedge clk) begin
    if (pat_valid && !prev_v) rise_cyc = n;
    if (pat_valid) vhigh_cnt++;
    prev_v = pat_valid;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  int m_row = 0;
  int m_col = 0;
  logic [24:0] m_edit = '0;

  function automatic logic [4:0] m_cursor();
    return 5'(m_row * 5 + m_col);
  endfunction

  task automatic model_event(input logic [5:0] mask);
    if (mask[5]) begin
      // commit handled by the caller
    end else if (mask[4]) m_edit[m_row * 5 + m_col] = ~m_edit[m_row * 5 + m_col];
    else if (mask[0]) m_row = (m_row + 4) % 5;
    else if (mask[1]) m_row = (m_row + 1) % 5;
    else if (mask[2]) m_col = (m_col + 4) % 5;
    else if (mask[3]) m_col = (m_col + 1) % 5;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Noise starting in cycle s: consume LFSR values until NF in-grid indices
  // are flipped; e is the cycle of the last flip.
  task automatic noise_model(input int s, input logic [24:0] base,
                             output logic [24:0] pat, output int e);
    logic [15:0] x;
    int left;
    x = 16'hACE1;
    for (int i = 0; i < s; i++) x = lfsr_step(x);
    left = NF;
    pat = base;
    e = -1;
    for (int c = s; c < s + 2000; c++) begin
      if (x[4:0] < 5'd25) begin
        pat[x[4:0]] = ~pat[x[4:0]];
        left--;
        if (left == 0) begin
          e = c;
          break;
        end
      end
      x = lfsr_step(x);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input logic [5:0] mask);
    @(negedge clk);
    btn = ~mask[3:0];
    Abtn = ~mask[4];
    Bbtn = ~mask[5];
    last_drive = n;
    repeat (10) @(negedge clk);
    btn = 4'hF;
    Abtn = 1'b1;
    Bbtn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    pat_ready = 1'b1;
    @(negedge clk);
    pat_ready = 1'b0;
    check(name, {31'd0, pat_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_row = 0;
    m_col = 0;
    m_edit = '0;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [5:0]  mask;
    logic [4:0]  exp_cur;
    logic [24:0] exp_edit;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic ok;
    logic [24:0] held, pat, npat;
    int lat, e;
    bit found;

    tbl[0]  = '{M_LT, 5'd4,  25'h0};
    tbl[1]  = '{M_UP, 5'd24, 25'h0};
    tbl[2]  = '{M_RT, 5'd20, 25'h0};
    tbl[3]  = '{M_DN, 5'd0,  25'h0};
    tbl[4]  = '{M_TG, 5'd0,  25'h1};
    tbl[5]  = '{M_DN, 5'd5,  25'h1};
    tbl[6]  = '{M_DN, 5'd10, 25'h1};
    tbl[7]  = '{M_RT, 5'd11, 25'h1};
    tbl[8]  = '{M_RT, 5'd12, 25'h1};
    tbl[9]  = '{M_TG, 5'd12, 25'h0001001};
    tbl[10] = '{M_TG, 5'd12, 25'h1};
    tbl[11] = '{M_UP, 5'd7,  25'h1};
    tbl[12] = '{M_UP, 5'd2,  25'h1};
    tbl[13] = '{M_LT, 5'd1,  25'h1};
    tbl[14] = '{M_LT, 5'd0,  25'h1};
    tbl[15] = '{M_TG, 5'd0,  25'h0};

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_edit", {7'd0, edit_buf}, 32'd0);
    check("rst_cursor", {27'd0, cursor}, 32'd0);
    check("rst_valid", {31'd0, pat_valid}, 32'd0);
    check("rst_data", {7'd0, pat_data}, 32'd0);
    check("rst_blink", {31'd0, blink}, 32'd0);
    do_reset();
    rise_cyc = -1;

    // Idle for 50 cycles: nothing moves
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (edit_buf !== 25'd0 || cursor !== 5'd0 || pat_valid !== 1'b0) ok = 1'b0;
    end
    check("idle_quiet", {31'd0, ok}, 32'd1);
    check("idle_no_rise", rise_cyc, -1);
    check("idle_blink", {31'd0, blink}, {31'd0, 1'(n >> BB)});

    // Table: cursor wrap moves and toggles at 0 and 12
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].mask);
      model_event(tbl[i].mask);
      check($sformatf("tbl%0d_cursor", i), {27'd0, cursor}, {27'd0, tbl[i].exp_cur});
      check($sformatf("tbl%0d_edit", i), {7'd0, edit_buf}, {7'd0, tbl[i].exp_edit});
    end

    // Clean commit held with pat_ready low
    noise_en = 1'b0;
    rise_cyc = -1;
    exp_q.push_back(m_edit);
    press(M_CM);
    lat = rise_cyc - last_drive;
    check("commit_valid", {31'd0, pat_valid}, 32'd1);
    check("commit_latency", {31'd0, (rise_cyc >= 0 && lat >= 6 && lat <= 8)}, 32'd1);
    held = exp_q.pop_front();
    check("commit_data", {7'd0, pat_data}, {7'd0, held});
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pat_valid !== 1'b1 || pat_data !== held) ok = 1'b0;
    end
    check("commit_hold", {31'd0, ok}, 32'd1);
    handshake("commit_xfer");
    check("edit_persist", {7'd0, edit_buf}, {7'd0, m_edit});

    // Table: clear the buffer back to zero
    for (int i = 10; i < 16; i++) begin
      press(tbl[i].mask);
      model_event(tbl[i].mask);
      check($sformatf("tbl%0d_cursor", i), {27'd0, cursor}, {27'd0, tbl[i].exp_cur});
      check($sformatf("tbl%0d_edit", i), {7'd0, edit_buf}, {7'd0, tbl[i].exp_edit});
    end

    // Noisy commit from all-zero
    noise_en = 1'b1;
    rise_cyc = -1;
    press(M_CM);
    noise_en = 1'b0;
    for (int i = 0; i < 50 && !pat_valid; i++) @(negedge clk);
    check("noise_valid", {31'd0, pat_valid}, 32'd1);
    found = 1'b0;
    for (int s = last_drive + 5; s <= last_drive + 9; s++) begin
      noise_model(s, m_edit, npat, e);
      if (e >= 0 && e + 1 == rise_cyc && npat === pat_data) found = 1'b1;
    end
    check("noise_pattern", {31'd0, found}, 32'd1);
    check("noise_popcount", {31'd0, ($countones(pat_data) == 1 || $countones(pat_data) == 3)}, 32'd1);
    check("noise_edit_kept", {7'd0, edit_buf}, {7'd0, m_edit});
    handshake("noise_xfer");

    // Toggle and right together: only the toggle acts
    press(M_TG | M_RT);
    model_event(M_TG | M_RT);
    check("simul_cursor", {27'd0, cursor}, {27'd0, m_cursor()});
    check("simul_edit", {7'd0, edit_buf}, {7'd0, m_edit});

    // Toggle during OFFER is dropped
    press(M_CM);
    pat = pat_data;
    press(M_TG);
    check("offer_edit", {7'd0, edit_buf}, {7'd0, m_edit});
    check("offer_valid", {31'd0, pat_valid}, 32'd1);
    check("offer_data", {7'd0, pat_data}, {7'd0, m_edit});
    check("offer_data_stable", {7'd0, pat_data}, {7'd0, pat});
    handshake("offer_xfer");

    // Constant ready gives a one-cycle valid pulse
    pat_ready = 1'b1;
    vhigh_cnt = 0;
    press(M_CM);
    pat_ready = 1'b0;
    check("pulse_len", vhigh_cnt, 1);

    // One-cycle glitch on toggle
    @(negedge clk);
    Abtn = 1'b0;
    @(negedge clk);
    Abtn = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_edit", {7'd0, edit_buf}, {7'd0, m_edit});

    // Randomized single-button events
    for (int i = 0; i < 16; i++) begin
      logic [5:0] mk;
      mk = 6'b1 << $urandom_range(0, 4);
      press(mk);
      model_event(mk);
      check($sformatf("rnd%0d_cursor", i), {27'd0, cursor}, {27'd0, m_cursor()});
      check($sformatf("rnd%0d_edit", i), {7'd0, edit_buf}, {7'd0, m_edit});
      check($sformatf("rnd%0d_blink", i), {31'd0, blink}, {31'd0, 1'(n >> BB)});
    end

    // Reset while offering
    if (m_edit == 25'd0) begin
      press(M_TG);
      model_event(M_TG);
    end
    press(M_CM);
    check("pre_rst_valid", {31'd0, pat_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, pat_valid}, 32'd0);
    check("arst_edit", {7'd0, edit_buf}, 32'd0);
    check("arst_cursor", {27'd0, cursor}, 32'd0);
    check("arst_data", {7'd0, pat_data}, 32'd0);
    check("arst_blink", {31'd0, blink}, 32'd0);
    do_reset();
    repeat (5) @(negedge clk);
    check("post_rst_valid", {31'd0, pat_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
